gpi: RTL and testbench



---
 rtl/gpi.sv | 89 ++++++++
 tb/tb_gpi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/gpi.sv
// rtl/gpi.sv - general-purpose input port: synchronizer, per-bit debounce, sticky edge events, read port
module gpi #(
   parameter int WIDTH    = 8,
   parameter int DEBOUNCE = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gpi_in,
   input  logic             re,
   input  logic [1:0]       addr,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_valid,
   output logic             irq
);

   localparam int            CW       = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic [WIDTH-1:0] sync1_q, sync2_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CW-1:0]    cnt_q [WIDTH];
   logic [CW-1:0]    cnt_d [WIDTH];
   logic [WIDTH-1:0] rise_q, rise_d;
   logic [WIDTH-1:0] fall_q, fall_d;
   logic [WIDTH-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q;
   logic [WIDTH-1:0] clr_rise, clr_fall;
   logic [WIDTH-1:0] rd_sel;

   // A change is accepted on the DEBOUNCE-th consecutive edge that sync2 disagrees with stable.
   always_comb begin
      stable_d = stable_q;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = '0;
         if (sync2_q[i] != stable_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               stable_d[i] = sync2_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
         end
      end
   end

   // New edges are OR-ed in after the clear so a same-edge event survives its clearing read.
   always_comb begin
      clr_rise = (re && (addr == 2'd1)) ? '1 : '0;
      clr_fall = (re && (addr == 2'd2)) ? '1 : '0;
      rise_d   = (rise_q & ~clr_rise) | (stable_d & ~stable_q);
      fall_d   = (fall_q & ~clr_fall) | (~stable_d & stable_q);
      case (addr)
         2'd0:    rd_sel = stable_q;
         2'd1:    rd_sel = rise_q;
         2'd2:    rd_sel = fall_q;
         default: rd_sel = '0;
      endcase
      rd_data_d = re ? rd_sel : rd_data_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q    <= '0;
         sync2_q    <= '0;
         stable_q   <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt_q[i] <= '0;
         end
         rise_q     <= '0;
         fall_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         sync1_q    <= gpi_in;
         sync2_q    <= sync1_q;
         stable_q   <= stable_d;
         cnt_q      <= cnt_d;
         rise_q     <= rise_d;
         fall_q     <= fall_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= re;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = |(rise_q | fall_q);

endmodule

// File: tb/tb_gpi.sv
// tb/tb_gpi.sv - self-checking bench for gpi against a sample-window reference model
module tb_gpi;

   localparam int W = 8;
   localparam int D = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] gpi_in;
   logic         re;
   logic [1:0]   addr;
   logic [W-1:0] rd_data;
   logic         rd_valid;
   logic         irq;

   int n_checks = 0;
   int n_errors = 0;

   // Model: stable flips when the last D synchronized samples all disagree with it.
   logic [W-1:0] hist [$];
   logic [W-1:0] m_stable, m_rise, m_fall, m_rd_data;
   logic         m_rd_valid;

   gpi #(.WIDTH(W), .DEBOUNCE(D)) dut (
      .clk      (clk),
      .rst      (rst),
      .gpi_in   (gpi_in),
      .re       (re),
      .addr     (addr),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .irq      (irq)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      hist.delete();
      for (int k = 0; k < D + 2; k++) hist.push_back('0);
      m_stable   = '0;
      m_rise     = '0;
      m_fall     = '0;
      m_rd_data  = '0;
      m_rd_valid = 1'b0;
   endtask

   task automatic model_edge();
      logic [W-1:0] nst;
      logic [W-1:0] rsel;
      bit           flip;
      hist.push_back(gpi_in);
      void'(hist.pop_front());
      nst = m_stable;
      for (int i = 0; i < W; i++) begin
         flip = 1'b1;
         for (int j = 0; j < D; j++) if (hist[j][i] == m_stable[i]) flip = 1'b0;
         if (flip) nst[i] = ~m_stable[i];
      end
      rsel = (addr == 2'd0) ? m_stable : (addr == 2'd1) ? m_rise : (addr == 2'd2) ? m_fall : '0;
      if (re) m_rd_data = rsel;
      m_rd_valid = re;
      m_rise   = ((re && addr == 2'd1) ? '0 : m_rise) | (nst & ~m_stable);
      m_fall   = ((re && addr == 2'd2) ? '0 : m_fall) | (~nst & m_stable);
      m_stable = nst;
   endtask

   task automatic tick();
      @(posedge clk);
      if (rst) model_reset();
      else model_edge();
      #1;
      chk("cyc_rd_valid", rd_valid, m_rd_valid);
      chk("cyc_rd_data", rd_data, m_rd_data);
      chk("cyc_irq", irq, |(m_rise | m_fall));
   endtask

   task automatic hold(input int n);
      repeat (n) tick();
   endtask

   task automatic rd(input logic [1:0] a);
      re   = 1'b1;
      addr = a;
      tick();
      re   = 1'b0;
   endtask

   initial begin
      rst = 1'b1; gpi_in = '0; re = 1'b0; addr = '0;
      model_reset();
      hold(3);
      rst = 1'b0;
      chk("reset_irq", irq, 0);
      chk("reset_valid", rd_valid, 0);
      chk("reset_data", rd_data, 0);
      for (int a = 0; a < 4; a++) begin
         rd(2'(a));
         chk("idle_rd_data", rd_data, 0);
         chk("idle_rd_valid", rd_valid, 1);
      end
      tick();
      chk("idle_valid_drop", rd_valid, 0);

      // Latency: edge N is the first tick after the pin changes; accepted at N+5.
      gpi_in = 8'h01;
      hold(5);
      chk("lat_before", irq, 0);
      tick();
      chk("lat_irq", irq, 1);
      rd(2'd0);
      chk("lat_rd0", rd_data, 8'h01);
      rd(2'd1);
      chk("lat_rd1", rd_data, 8'h01);
      chk("lat_irq_clr", irq, 0);

      gpi_in = 8'h00;
      hold(8);
      rd(2'd2);
      chk("fall_b0", rd_data, 8'h01);

      // Glitches: 3-cycle pulse rejected, 4-cycle pulse accepted.
      gpi_in = 8'h08; hold(3); gpi_in = 8'h00; hold(10);
      chk("glitch_irq", irq, 0);
      rd(2'd0);
      chk("glitch_stable", rd_data, 8'h00);
      gpi_in = 8'h08; hold(4); gpi_in = 8'h00; hold(10);
      rd(2'd1);
      chk("pulse_rise", rd_data, 8'h08);
      rd(2'd2);
      chk("pulse_fall", rd_data, 8'h08);
      chk("pulse_irq_clr", irq, 0);

      // Set-wins collision between bit 2's rise and an addr=1 read.
      gpi_in = 8'h01; hold(6);
      chk("coll_pre_irq", irq, 1);
      gpi_in = 8'h05; hold(5);
      rd(2'd1);
      chk("coll_rd", rd_data, 8'h01);
      chk("coll_irq", irq, 1);
      rd(2'd1);
      chk("coll_rise_after", rd_data, 8'h04);
      gpi_in = 8'h00; hold(8);
      rd(2'd2);
      chk("coll_fall", rd_data, 8'h05);

      // Multi-bit patterns.
      gpi_in = 8'hA5; hold(10);
      gpi_in = 8'h5A; hold(10);
      rd(2'd2);
      chk("multi_fall", rd_data, 8'hA5);
      rd(2'd2);
      chk("multi_fall_clr", rd_data, 8'h00);
      chk("multi_irq", irq, 1);
      rd(2'd1);
      chk("multi_rise", rd_data, 8'hFF);
      chk("multi_irq_clr", irq, 0);

      // Async reset in the middle of a debounce count.
      gpi_in = 8'h5B; hold(6);
      gpi_in = 8'hDB; hold(3);
      rd(2'd0);
      chk("ar_pre_data", rd_data, 8'h5B);
      chk("ar_pre_irq", irq, 1);
      #2 rst = 1'b1;
      #1;
      chk("ar_irq", irq, 0);
      chk("ar_valid", rd_valid, 0);
      chk("ar_data", rd_data, 0);
      model_reset();
      hold(2);
      rst = 1'b0;
      hold(5);
      chk("ar_relatch_before", irq, 0);
      tick();
      chk("ar_relatch_irq", irq, 1);
      rd(2'd0);
      chk("ar_stable", rd_data, 8'hDB);
      rd(2'd1);
      chk("ar_rise", rd_data, 8'hDB);

      // Randomized pins and reads against the model.
      repeat (600) begin
         case ($urandom_range(0, 7))
            0:       gpi_in = W'($urandom);
            1, 2:    gpi_in = gpi_in ^ (W'(1) << $urandom_range(0, W - 1));
            default: ;
         endcase
         re   = ($urandom_range(0, 2) == 0);
         addr = 2'($urandom_range(0, 3));
         tick();
      end
      re = 1'b0;
      hold(2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
